// File: rtl/ysyx_23060236_clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp with a prescaled tick and a registered timer interrupt.
// Latency: every accepted request answers exactly one cycle later; time_intr trails register updates by one cycle.
// Backpressure: one request in flight; req_ready drops while a response waits and the response holds until resp_ready.
module ysyx_23060236_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        time_intr
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    state_t      state;
    state_t      state_next;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] prescaler;

    logic        in_window;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mtime_lo;
    logic        sel_mtime_hi;
    logic        mapped;
    logic [31:0] read_mux;
    logic        accept;
    logic        wr;
    logic        tick;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Address decode and read-data selection for the current request.
    always_comb begin
        in_window    = (req_addr[31:16] == BASE_ADDR[31:16]);
        sel_cmp_lo   = in_window && (req_addr[15:0] == OFF_CMP_LO);
        sel_cmp_hi   = in_window && (req_addr[15:0] == OFF_CMP_HI);
        sel_mtime_lo = in_window && (req_addr[15:0] == OFF_MTIME_LO);
        sel_mtime_hi = in_window && (req_addr[15:0] == OFF_MTIME_HI);
        mapped       = sel_cmp_lo || sel_cmp_hi || sel_mtime_lo || sel_mtime_hi;
        read_mux     = 32'h0;
        if (sel_cmp_lo)   read_mux = mtimecmp[31:0];
        if (sel_cmp_hi)   read_mux = mtimecmp[63:32];
        if (sel_mtime_lo) read_mux = mtime[31:0];
        if (sel_mtime_hi) read_mux = mtime[63:32];
    end

    assign accept = req_valid && req_ready;
    assign wr     = accept && req_wen;
    assign tick   = (prescaler == PRE_LAST);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: accept in IDLE, leave RESP on the response handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid)  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake signals are pure functions of state.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    // Prescaler free-runs 0..TICK_DIV-1; bus writes never disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= 16'h0;
        end else if (tick) begin
            prescaler <= 16'h0;
        end else begin
            prescaler <= prescaler + 16'h1;
        end
    end

    // mtime: a bus write to either half wins over the tick, with no carry into the other half.
    always_ff @(posedge clock) begin
        if (reset) begin
            mtime <= 64'h0;
        end else if (wr && sel_mtime_lo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], req_wdata, req_wstrb);
        end else if (wr && sel_mtime_hi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], req_wdata, req_wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'h1;
        end
    end

    // mtimecmp: byte-wise writes; resets to all ones so no interrupt fires before software programs it.
    always_ff @(posedge clock) begin
        if (reset) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (wr && sel_cmp_lo) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], req_wdata, req_wstrb);
            end
            if (wr && sel_cmp_hi) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], req_wdata, req_wstrb);
            end
        end
    end

    // Timer interrupt level from the current register values.
    always_ff @(posedge clock) begin
        if (reset) begin
            time_intr <= 1'b0;
        end else begin
            time_intr <= (mtime >= mtimecmp);
        end
    end

    // Response capture at acceptance; held unchanged while the response waits.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_rdata <= (req_wen || !mapped) ? 32'h0 : read_mux;
            resp_err   <= !mapped;
        end
    end

endmodule
